// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory bus between instruction fetch and the MEM stage.
// Data accesses win by default; a starvation counter forces a fetch after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          dm_re,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] starve_cnt;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          dreq;
    logic          force_i;
    logic          grant_d;
    logic          grant_i;
    logic          ack_i;
    logic          ack_d;

    assign dreq    = dm_re | dm_we;
    assign force_i = if_req && (starve_cnt == STARVE_LIM);
    assign grant_d = (state == IDLE) && dreq && !force_i;
    assign grant_i = (state == IDLE) && !grant_d && if_req;
    assign ack_i   = (state == BUSY_I) && mem_ack;
    assign ack_d   = (state == BUSY_D) && mem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every grant returns through IDLE, so an access always takes at least two edges.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = BUSY_D;
                end else if (grant_i) begin
                    next_state = BUSY_I;
                end
            end
            BUSY_I: if (mem_ack) next_state = IDLE;
            BUSY_D: if (mem_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read data is bypassed during its own ack cycle so the stage can advance on that edge.
    always_comb begin
        mem_req  = (state != IDLE);
        if_stall = if_req & !ack_i;
        dm_stall = dreq & !ack_d;
        if_rdata = ack_i ? mem_rdata : if_rdata_q;
        dm_rdata = (ack_d && !mem_we) ? mem_rdata : dm_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant_d) begin
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_we    <= dm_we;
            end else if (grant_i) begin
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
            end
            if (ack_i) begin
                if_rdata_q <= mem_rdata;
            end
            if (ack_d && !mem_we) begin
                dm_rdata_q <= mem_rdata;
            end
            if (!if_req || grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule
